layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 8, number of layer-table entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of per-layer repeat count.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 io_clk  in  1  clock, all logic on rising edge.
REQ-005 io_rst  in  1  synchronous active-high reset.
REQ-006 io_wrEn  in  1  table write strobe.
REQ-007 io_wrAddr  in  log2(NUM_LAYERS)  table entry index.
REQ-008 io_wrCfg  in  8  switch-enable mask for entry.
REQ-009 io_wrCnt  in  CNT_W  repeat count for entry.
REQ-010 io_wrMode  in  1  workingMode for entry (1 = delay-end, 0 = feedback-catch).
REQ-011 io_lastLayer  in  log2(NUM_LAYERS)  index of final layer in sequence.
REQ-012 io_loopEn  in  1  1 = wrap to layer 0 after final layer; 0 = stop.
REQ-013 io_start  in  1  start pulse.
REQ-014 io_abort  in  1  abort pulse.
REQ-015 io_layerEnd  in  1  end-of-layer pulse from the layer counter stage.
REQ-016 io_layerCfg  out  8  current layer mask to the layer counter stage.
REQ-017 io_layerCnt  out  CNT_W  current repeat count.
REQ-018 io_workingMode  out  1  current layer mode.
REQ-019 io_BaseLayer  out  1  high when current index is 0.
REQ-020 io_layerClr  out  1  one-cycle clear pulse to the layer counter stage.
REQ-021 io_layerIdx  out  log2(NUM_LAYERS)  current layer index.
REQ-022 io_busy  out  1  high in RUN.
REQ-023 io_seqDone  out  1  one-cycle pulse on sequence completion.
REQ-024 io_loopCount  out  16  completed loop passes.

Function
REQ-025 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-026 Table write SHALL occur on io_wrEn only in IDLE or DONE; writes in RUN SHALL be ignored.
REQ-027 IDLE/DONE + io_start (no abort) SHALL enter RUN next cycle with io_layerIdx=0, io_loopCount=0, io_layerClr=1 for that one cycle.
REQ-028 In RUN, io_layerCfg/io_layerCnt/io_workingMode SHALL equal table[io_layerIdx], updated in the same cycle io_layerIdx changes.
REQ-029 Outside RUN, io_layerCfg SHALL be 0x00, io_layerCnt 0, io_workingMode 0.
REQ-030 io_BaseLayer SHALL be 1 iff io_layerIdx==0, in every state.
REQ-031 RUN + io_layerEnd, io_layerIdx != effective last: io_layerIdx+1 next cycle, io_layerClr pulses 1 cycle.
REQ-032 Effective last index SHALL be min(io_lastLayer, NUM_LAYERS-1), sampled each cycle.
REQ-033 RUN + io_layerEnd at effective last, io_loopEn=1: io_layerIdx wraps to 0, io_loopCount increments (saturating at 0xFFFF), io_layerClr pulses.
REQ-034 RUN + io_layerEnd at effective last, io_loopEn=0: enter DONE, io_seqDone pulse 1 cycle, io_layerIdx held.
REQ-035 io_abort in any state SHALL enter IDLE next cycle, io_layerIdx=0; abort wins over simultaneous io_start and io_layerEnd; no io_seqDone.
REQ-036 io_start in RUN SHALL be ignored; io_layerEnd outside RUN SHALL be ignored.
REQ-037 io_loopCount SHALL hold its value in DONE and IDLE until the next start.
REQ-038 Latency from io_layerEnd to new io_layerCfg SHALL be exactly one cycle.

Reset
REQ-039 io_rst SHALL force IDLE, io_layerIdx=0, io_loopCount=0, all pulses 0, io_layerCfg=0, io_busy=0, io_BaseLayer=1.
REQ-040 Table contents SHALL reset to cfg=0x00, cnt=0, mode=0.
REQ-041 io_rst mid-RUN SHALL take effect next edge, overriding all other inputs.

Verification
REQ-042 Write entries 0..2 (cfg 0x01/0x02/0x04, cnt 3/5/7), lastLayer=2, loopEn=0, start, three io_layerEnd pulses -> cfg sequence 0x01,0x02,0x04; io_seqDone once; state DONE, idx=2.
REQ-043 Same table, loopEn=1, seven io_layerEnd pulses -> io_loopCount=2, idx=1, cfg=0x02, io_layerClr pulsed 8 times including start.
REQ-044 io_abort and io_layerEnd same cycle in RUN at idx=1 -> IDLE, idx=0, cfg=0x00, no io_seqDone.
REQ-045 io_wrEn to entry 0 during RUN with cfg 0xFF -> table unchanged; after return to IDLE, io_layerCfg=0x00.
REQ-046 io_lastLayer=15 with NUM_LAYERS=8, loopEn=0 -> io_seqDone after 8th io_layerEnd at idx=7.
REQ-047 io_rst asserted in RUN at idx=3 -> next cycle all outputs at reset values, io_BaseLayer=1.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps a small layer table (mask, repeat count, mode) through a
// sequence of layers, one layer per io_layerEnd, with optional looping.
//   io_clk/io_rst             clock, synchronous active-high reset
//   io_wrEn/io_wrAddr/io_wrCfg/io_wrCnt/io_wrMode   table write port (IDLE/DONE only)
//   io_lastLayer/io_loopEn    final layer index, wrap-around enable
//   io_start/io_abort         sequence control pulses
//   io_layerEnd               end-of-layer pulse from the layer counter stage
//   io_layerCfg/io_layerCnt/io_workingMode   current table entry (zero outside RUN)
//   io_BaseLayer/io_layerIdx  current index and index==0 flag
//   io_layerClr/io_seqDone    one-cycle clear / completion pulses
//   io_busy/io_loopCount      RUN flag, completed loop passes
module layer_sequencer #(
    parameter int NUM_LAYERS = 8,
    parameter int CNT_W      = 16,
    localparam int AW        = $clog2(NUM_LAYERS)
) (
    input  logic             io_clk,
    input  logic             io_rst,
    input  logic             io_wrEn,
    input  logic [AW-1:0]    io_wrAddr,
    input  logic [7:0]       io_wrCfg,
    input  logic [CNT_W-1:0] io_wrCnt,
    input  logic             io_wrMode,
    input  logic [AW-1:0]    io_lastLayer,
    input  logic             io_loopEn,
    input  logic             io_start,
    input  logic             io_abort,
    input  logic             io_layerEnd,
    output logic [7:0]       io_layerCfg,
    output logic [CNT_W-1:0] io_layerCnt,
    output logic             io_workingMode,
    output logic             io_BaseLayer,
    output logic             io_layerClr,
    output logic [AW-1:0]    io_layerIdx,
    output logic             io_busy,
    output logic             io_seqDone,
    output logic [15:0]      io_loopCount
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [7:0]       cfg_tbl_q  [NUM_LAYERS];
    logic [CNT_W-1:0] cnt_tbl_q  [NUM_LAYERS];
    logic             mode_tbl_q [NUM_LAYERS];
    logic [AW-1:0]    idx_q;
    logic [15:0]      loop_q;
    logic [7:0]       cfg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q, base_q, clr_q, busy_q, done_q;
    logic             wr_ok, at_last;
    logic [AW-1:0]    step_idx;
    logic [7:0]       cfg0;
    logic [CNT_W-1:0] cnt0;
    logic             mode0;

    // io_lastLayer is AW bits wide, so it can never exceed NUM_LAYERS-1 and the
    // min() clamp is implicit.
    always_comb begin
        wr_ok    = io_wrEn && state_q != RUN;
        at_last  = idx_q == io_lastLayer;
        step_idx = at_last ? '0 : idx_q + AW'(1);
        // Entry 0 is forwarded from the write port so a write coinciding with
        // start is seen by the first layer.
        cfg0     = (wr_ok && io_wrAddr == '0) ? io_wrCfg  : cfg_tbl_q[0];
        cnt0     = (wr_ok && io_wrAddr == '0) ? io_wrCnt  : cnt_tbl_q[0];
        mode0    = (wr_ok && io_wrAddr == '0) ? io_wrMode : mode_tbl_q[0];
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                cfg_tbl_q[i]  <= '0;
                cnt_tbl_q[i]  <= '0;
                mode_tbl_q[i] <= 1'b0;
            end
        end else if (wr_ok) begin
            cfg_tbl_q[io_wrAddr]  <= io_wrCfg;
            cnt_tbl_q[io_wrAddr]  <= io_wrCnt;
            mode_tbl_q[io_wrAddr] <= io_wrMode;
        end
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            loop_q  <= '0;
            cfg_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            base_q  <= 1'b1;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            if (io_abort) begin
                state_q <= IDLE;
                idx_q   <= '0;
                base_q  <= 1'b1;
                cfg_q   <= '0;
                cnt_q   <= '0;
                mode_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else if (state_q != RUN) begin
                if (io_start) begin
                    state_q <= RUN;
                    idx_q   <= '0;
                    base_q  <= 1'b1;
                    loop_q  <= '0;
                    clr_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    cfg_q   <= cfg0;
                    cnt_q   <= cnt0;
                    mode_q  <= mode0;
                end
            end else if (io_layerEnd) begin
                if (!at_last || io_loopEn) begin
                    idx_q  <= step_idx;
                    base_q <= step_idx == '0;
                    clr_q  <= 1'b1;
                    cfg_q  <= cfg_tbl_q[step_idx];
                    cnt_q  <= cnt_tbl_q[step_idx];
                    mode_q <= mode_tbl_q[step_idx];
                    if (at_last)
                        loop_q <= loop_q + 16'(loop_q != 16'hFFFF);
                end else begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cfg_q   <= '0;
                    cnt_q   <= '0;
                    mode_q  <= 1'b0;
                end
            end
        end
    end

    assign io_layerCfg    = cfg_q;
    assign io_layerCnt    = cnt_q;
    assign io_workingMode = mode_q;
    assign io_BaseLayer   = base_q;
    assign io_layerClr    = clr_q;
    assign io_layerIdx    = idx_q;
    assign io_busy        = busy_q;
    assign io_seqDone     = done_q;
    assign io_loopCount   = loop_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scenarios plus random traffic against a table-based reference model.
module tb_layer_sequencer;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0, wr_en = 1'b0, wr_mode = 1'b0, loop_en = 1'b0;
    logic          start = 1'b0, abort = 1'b0, layer_end = 1'b0;
    logic [AW-1:0] wr_addr = '0, last_layer = '0;
    logic [7:0]    wr_cfg = '0;
    logic [CW-1:0] wr_cnt = '0;
    logic [7:0]    layer_cfg;
    logic [CW-1:0] layer_cnt;
    logic          working_mode, base_layer, layer_clr, busy, seq_done;
    logic [AW-1:0] layer_idx;
    logic [15:0]   loop_count;

    layer_sequencer #(.NUM_LAYERS(N), .CNT_W(CW)) dut (
        .io_clk(clk), .io_rst(rst), .io_wrEn(wr_en), .io_wrAddr(wr_addr),
        .io_wrCfg(wr_cfg), .io_wrCnt(wr_cnt), .io_wrMode(wr_mode),
        .io_lastLayer(last_layer), .io_loopEn(loop_en), .io_start(start),
        .io_abort(abort), .io_layerEnd(layer_end), .io_layerCfg(layer_cfg),
        .io_layerCnt(layer_cnt), .io_workingMode(working_mode),
        .io_BaseLayer(base_layer), .io_layerClr(layer_clr), .io_layerIdx(layer_idx),
        .io_busy(busy), .io_seqDone(seq_done), .io_loopCount(loop_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int clr_seen = 0, sd_seen = 0;

    // reference model: table contents plus "running?", index, loop passes
    int m_cfg [N], m_cnt [N], m_mode [N];
    bit m_run, m_clr, m_sd;
    int m_idx, m_loops;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_step();
        int last;
        if (rst) begin
            foreach (m_cfg[i]) begin m_cfg[i] = 0; m_cnt[i] = 0; m_mode[i] = 0; end
            m_run = 0; m_idx = 0; m_loops = 0; m_clr = 0; m_sd = 0;
            return;
        end
        m_clr = 0;
        m_sd  = 0;
        if (wr_en && !m_run) begin
            m_cfg[wr_addr] = wr_cfg; m_cnt[wr_addr] = wr_cnt; m_mode[wr_addr] = wr_mode;
        end
        last = (int'(last_layer) < N - 1) ? int'(last_layer) : N - 1;
        if (abort) begin
            m_run = 0; m_idx = 0;
        end else if (!m_run) begin
            if (start) begin m_run = 1; m_idx = 0; m_loops = 0; m_clr = 1; end
        end else if (layer_end) begin
            if (m_idx != last) begin
                m_idx = (m_idx + 1) % N; m_clr = 1;
            end else if (loop_en) begin
                m_idx = 0; m_clr = 1;
                if (m_loops < 65535) m_loops++;
            end else begin
                m_run = 0; m_sd = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cfg",   32'(layer_cfg),    m_run ? 32'(m_cfg[m_idx])  : 0);
        chk("cnt",   32'(layer_cnt),    m_run ? 32'(m_cnt[m_idx])  : 0);
        chk("mode",  32'(working_mode), m_run ? 32'(m_mode[m_idx]) : 0);
        chk("idx",   32'(layer_idx),    32'(m_idx));
        chk("base",  32'(base_layer),   32'(m_idx == 0));
        chk("busy",  32'(busy),         32'(m_run));
        chk("clr",   32'(layer_clr),    32'(m_clr));
        chk("sdone", 32'(seq_done),     32'(m_sd));
        chk("loops", 32'(loop_count),   32'(m_loops));
        clr_seen += int'(layer_clr);
        sd_seen  += int'(seq_done);
        rst = 0; abort = 0; start = 0; layer_end = 0; wr_en = 0;
    endtask

    task automatic wr(int a, int c, int n, int m);
        wr_en = 1; wr_addr = AW'(a); wr_cfg = 8'(c); wr_cnt = CW'(n); wr_mode = m[0];
        tick();
    endtask

    task automatic ends(int k);
        for (int i = 0; i < k; i++) begin layer_end = 1; tick(); tick(); end
    endtask

    initial begin
        rst = 1;
        tick();
        chk("rst_base", 32'(base_layer), 1);
        // three-layer single pass
        wr(0, 8'h01, 3, 0); wr(1, 8'h02, 5, 1); wr(2, 8'h04, 7, 0);
        last_layer = 2; loop_en = 0;
        start = 1; tick();
        chk("pass_cfg0", 32'(layer_cfg), 32'h01);
        layer_end = 1; tick(); chk("pass_cfg1", 32'(layer_cfg), 32'h02);
        layer_end = 1; tick(); chk("pass_cfg2", 32'(layer_cfg), 32'h04);
        sd_seen = 0;
        ends(1);
        chk("pass_sd_once", 32'(sd_seen), 1);
        chk("pass_idx", 32'(layer_idx), 2);
        // looping: seven ends
        loop_en = 1; clr_seen = 0;
        start = 1; tick();
        ends(7);
        chk("loop_cnt", 32'(loop_count), 2);
        chk("loop_idx", 32'(layer_idx), 1);
        chk("loop_cfg", 32'(layer_cfg), 32'h02);
        chk("loop_clrs", 32'(clr_seen), 8);
        // abort beats layerEnd at idx 1 (still running from the loop test)
        sd_seen = 0;
        abort = 1; layer_end = 1; tick();
        chk("abort_idx", 32'(layer_idx), 0);
        chk("abort_cfg", 32'(layer_cfg), 0);
        chk("abort_sd", 32'(sd_seen), 0);
        // write during RUN is dropped
        start = 1; tick();
        wr(0, 8'hFF, 99, 1);
        abort = 1; tick();
        chk("ro_idle_cfg", 32'(layer_cfg), 0);
        start = 1; tick();
        chk("ro_cfg0", 32'(layer_cfg), 32'h01);
        abort = 1; tick();
        // lastLayer beyond the table clamps to the final entry
        for (int i = 3; i < N; i++) wr(i, 1 << i, i * 10, i & 1);
        last_layer = AW'(15); loop_en = 0; sd_seen = 0;
        start = 1; tick();
        ends(7);
        chk("clamp_nosd", 32'(sd_seen), 0);
        ends(1);
        chk("clamp_sd", 32'(sd_seen), 1);
        chk("clamp_idx", 32'(layer_idx), 7);
        // reset mid-run at idx 3 overrides layerEnd
        start = 1; tick();
        ends(3);
        chk("mid_idx3", 32'(layer_idx), 3);
        rst = 1; layer_end = 1; start = 1; tick();
        chk("mid_rst_base", 32'(base_layer), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        // random traffic
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom % 300) == 0;
            abort     = ($urandom % 40) == 0;
            start     = ($urandom % 8) == 0;
            layer_end = ($urandom % 2) == 0;
            wr_en     = ($urandom % 4) == 0;
            wr_addr   = AW'($urandom);
            wr_cfg    = 8'($urandom);
            wr_cnt    = CW'($urandom);
            wr_mode   = 1'($urandom);
            if (($urandom % 20) == 0) begin
                last_layer = AW'($urandom);
                loop_en    = 1'($urandom);
            end
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
